// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor sequencer.
// Holds the command codes, ALU opcodes, FSM state type, matrix geometry and an
// element slice helper for the flat 200-bit operand/result buses.
package coproc_pkg;

  localparam int unsigned N_ELEM         = 25;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned FLAT_W         = N_ELEM * DATA_W;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned CNT_W          = 7;

  // Host command codes
  localparam logic [2:0] CmdNop      = 3'b000;
  localparam logic [2:0] CmdWriteA   = 3'b001;
  localparam logic [2:0] CmdWriteB   = 3'b010;
  localparam logic [2:0] CmdWriteF   = 3'b011;
  localparam logic [2:0] CmdExec     = 3'b100;
  localparam logic [2:0] CmdReadC    = 3'b101;
  localparam logic [2:0] CmdClear    = 3'b110;
  localparam logic [2:0] CmdReserved = 3'b111;

  // ALU opcodes
  localparam logic [2:0] AluIdle      = 3'b000;
  localparam logic [2:0] AluAdd       = 3'b001;
  localparam logic [2:0] AluSub       = 3'b010;
  localparam logic [2:0] AluMul       = 3'b011;
  localparam logic [2:0] AluNeg       = 3'b100;
  localparam logic [2:0] AluTranspose = 3'b101;
  localparam logic [2:0] AluScalar    = 3'b110;
  localparam logic [2:0] AluDet       = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StSettle,
    StWait
  } state_e;

  // Element i of a row-major flat matrix lives at bits [i*8 +: 8].
  function automatic logic [DATA_W-1:0] get_elem(input logic [FLAT_W-1:0] flat,
                                                 input logic [4:0] idx);
    return flat[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/matrix_bank.sv
// 25 x 8-bit register bank for one matrix operand.
// Ports: clock, reset_n (sync active-low), we/addr/data (write one element),
// clear (zero all elements), flat (row-major 200-bit view of the bank).
// The caller guarantees addr is in range whenever we is high.
module matrix_bank
  import coproc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic              clear,
  input  logic [4:0]        addr,
  input  logic [DATA_W-1:0] data,
  output logic [FLAT_W-1:0] flat
);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      flat <= '0;
    end else if (we) begin
      flat[addr*DATA_W +: DATA_W] <= data;
    end
  end

endmodule

// File: rtl/coproc_sequencer.sv
// Command sequencer for the 5x5 int8 matrix ALU.
// Host side: cmd_valid/cmd_ready/cmd_code/cmd_addr/cmd_data in, one-cycle
// rsp_valid/rsp_data/rsp_error pulse out, busy and overflow_sticky status.
// ALU side: alu_A_flat/alu_B_flat/alu_f operands and alu_opcode out,
// alu_C_flat/alu_overflow_flag/alu_done in. Exec waits for done with a timeout.
module coproc_sequencer
  import coproc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_code,
  input  logic [4:0]        cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              busy,
  output logic              overflow_sticky,
  output logic [FLAT_W-1:0] alu_A_flat,
  output logic [FLAT_W-1:0] alu_B_flat,
  output logic [DATA_W-1:0] alu_f,
  output logic [2:0]        alu_opcode,
  input  logic [FLAT_W-1:0] alu_C_flat,
  input  logic              alu_overflow_flag,
  input  logic              alu_done
);

  localparam logic [4:0]       MaxAddr  = 5'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] LastWait = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state;
  logic [CNT_W-1:0]    counter;
  logic [2:0]          exec_op;
  logic [FLAT_W-1:0]   c_q;
  logic [DATA_W-1:0]   f_q;

  logic accept;
  logic addr_ok;
  logic exec_ok;
  logic we_a;
  logic we_b;
  logic clr;

  always_comb begin
    cmd_ready = (state == StIdle);
    busy      = (state != StIdle);
    accept    = cmd_valid && cmd_ready;
    addr_ok   = (cmd_addr <= MaxAddr);
    exec_ok   = (cmd_code == CmdExec) && (cmd_data[2:0] != AluIdle);
    we_a      = accept && (cmd_code == CmdWriteA) && addr_ok;
    we_b      = accept && (cmd_code == CmdWriteB) && addr_ok;
    clr       = accept && (cmd_code == CmdClear);
  end

  assign alu_f = f_q;

  matrix_bank u_bank_a (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we_a),
    .clear   (clr),
    .addr    (cmd_addr),
    .data    (cmd_data),
    .flat    (alu_A_flat)
  );

  matrix_bank u_bank_b (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we_b),
    .clear   (clr),
    .addr    (cmd_addr),
    .data    (cmd_data),
    .flat    (alu_B_flat)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= StIdle;
      counter         <= '0;
      exec_op         <= AluIdle;
      c_q             <= '0;
      f_q             <= '0;
      overflow_sticky <= 1'b0;
      alu_opcode      <= AluIdle;
      rsp_valid       <= 1'b0;
      rsp_error       <= 1'b0;
      rsp_data        <= '0;
    end else begin
      // Response outputs are a single-cycle pulse coinciding with StResp.
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_data  <= '0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            if (exec_ok) begin
              exec_op <= cmd_data[2:0];
              state   <= StSettle;
            end else begin
              state     <= StResp;
              rsp_valid <= 1'b1;
              case (cmd_code)
                CmdWriteA, CmdWriteB: rsp_error <= !addr_ok;
                CmdWriteF:            f_q <= cmd_data;
                CmdReadC: begin
                  if (addr_ok) rsp_data  <= get_elem(c_q, cmd_addr);
                  else         rsp_error <= 1'b1;
                end
                CmdClear: begin
                  c_q             <= '0;
                  f_q             <= '0;
                  overflow_sticky <= 1'b0;
                end
                CmdExec, CmdReserved: rsp_error <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        StResp: state <= StIdle;
        // One cycle with opcode idle so the ALU drops any stale done.
        StSettle: begin
          state      <= StWait;
          alu_opcode <= exec_op;
          counter    <= '0;
        end
        StWait: begin
          // Done in the first wait cycle may still belong to a previous op.
          if (alu_done && (counter != '0)) begin
            c_q             <= alu_C_flat;
            overflow_sticky <= overflow_sticky | alu_overflow_flag;
            rsp_data        <= {{(DATA_W-1){1'b0}}, alu_overflow_flag};
            rsp_valid       <= 1'b1;
            alu_opcode      <= AluIdle;
            state           <= StResp;
          end else if (counter == LastWait) begin
            rsp_valid  <= 1'b1;
            rsp_error  <= 1'b1;
            alu_opcode <= AluIdle;
            state      <= StResp;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_sequencer.sv
// Scoreboard bench for coproc_sequencer: directed commands push the expected
// response into a queue, a negedge monitor pops and compares on rsp_valid.
// A small behavioural ALU stand-in provides done/overflow/C with set latency.
module tb_coproc_sequencer;

  logic         clock;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_code;
  logic [4:0]   cmd_addr;
  logic [7:0]   cmd_data;
  logic         rsp_valid;
  logic [7:0]   rsp_data;
  logic         rsp_error;
  logic         busy;
  logic         overflow_sticky;
  logic [199:0] alu_A_flat;
  logic [199:0] alu_B_flat;
  logic [7:0]   alu_f;
  logic [2:0]   alu_opcode;
  logic [199:0] alu_C_flat;
  logic         alu_overflow_flag;
  logic         alu_done;

  coproc_sequencer dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_addr          (cmd_addr),
    .cmd_data          (cmd_data),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_error         (rsp_error),
    .busy              (busy),
    .overflow_sticky   (overflow_sticky),
    .alu_A_flat        (alu_A_flat),
    .alu_B_flat        (alu_B_flat),
    .alu_f             (alu_f),
    .alu_opcode        (alu_opcode),
    .alu_C_flat        (alu_C_flat),
    .alu_overflow_flag (alu_overflow_flag),
    .alu_done          (alu_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  // ALU stand-in: done rises m_lat cycles after the opcode goes non-idle.
  int   m_cnt   = 0;
  int   m_lat   = 1;
  logic m_never = 1'b0;
  logic m_ovf   = 1'b0;

  always @(posedge clock) m_cnt <= (alu_opcode != 3'b000) ? m_cnt + 1 : 0;

  assign alu_done          = (alu_opcode != 3'b000) && !m_never && (m_cnt >= m_lat);
  assign alu_overflow_flag = m_ovf;

  always_comb begin
    alu_C_flat = '0;
    for (int i = 0; i < 25; i++) begin
      case (alu_opcode)
        3'b001:  alu_C_flat[i*8 +: 8] = alu_A_flat[i*8 +: 8] + alu_B_flat[i*8 +: 8];
        3'b011:  alu_C_flat[i*8 +: 8] = alu_A_flat[i*8 +: 8] * alu_B_flat[i*8 +: 8];
        default: alu_C_flat[i*8 +: 8] = 8'hAA;
      endcase
    end
  end

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clock) begin
    if (reset_n && rsp_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h err %0b, no response required",
                 rsp_data, rsp_error);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_data, rsp_error} !== mon_exp) begin
          n_fail++;
          $display("FAIL rsp: got data 0x%0h err %0b, required data 0x%0h err %0b",
                   rsp_data, rsp_error, mon_exp[8:1], mon_exp[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [4:0] addr, input logic [7:0] data,
                       input logic [7:0] exp_d, input logic exp_e, input logic push);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin
      tick();
      t++;
    end
    check("cmd_ready_before_issue", cmd_ready, 1'b1);
    if (push) exp_q.push_back({exp_d, exp_e});
    cmd_code  = code;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic simple_cmd(input logic [2:0] code, input logic [4:0] addr, input logic [7:0] data,
                            input logic [7:0] exp_d, input logic exp_e);
    issue(code, addr, data, exp_d, exp_e, 1'b1);
    check("rsp_valid_cycle_n1", rsp_valid, 1'b1);
    tick();
    check("rsp_valid_cycle_n2", rsp_valid, 1'b0);
  endtask

  task automatic run_exec(input logic [2:0] op, input logic [7:0] exp_d, input logic exp_e,
                          input int exp_busy, input int exp_opcyc, input logic ghost);
    int   nb;
    int   no;
    logic op_ok;
    nb    = 0;
    no    = 0;
    op_ok = 1'b1;
    issue(3'b100, 5'd0, {5'b0, op}, exp_d, exp_e, 1'b1);
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      nb++;
      if (alu_opcode != 3'b000) begin
        no++;
        if (alu_opcode !== op) op_ok = 1'b0;
      end
      if (ghost) begin
        cmd_code  = 3'b001;
        cmd_addr  = 5'd1;
        cmd_data  = 8'h55;
        cmd_valid = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("exec_busy_cycles", nb, exp_busy);
    check("exec_opcode_cycles", no, exp_opcyc);
    check("exec_opcode_value", op_ok, 1'b1);
    check("exec_opcode_idle_after", alu_opcode, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_code  = 3'b000;
    cmd_addr  = 5'd0;
    cmd_data  = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_opcode", alu_opcode, 3'b000);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_a", alu_A_flat, 200'd0);
    check("reset_b", alu_B_flat, 200'd0);
    check("reset_f", alu_f, 8'h00);
    check("reset_sticky", overflow_sticky, 1'b0);

    // Element writes at both ends of the matrix.
    simple_cmd(3'b001, 5'd0, 8'h03, 8'h00, 1'b0);
    simple_cmd(3'b001, 5'd24, 8'h07, 8'h00, 1'b0);
    check("a_elem0", alu_A_flat[7:0], 8'h03);
    check("a_elem24", alu_A_flat[199:192], 8'h07);

    // Error paths: out-of-range address and reserved code.
    simple_cmd(3'b010, 5'd25, 8'hFF, 8'h00, 1'b1);
    simple_cmd(3'b111, 5'd0, 8'h00, 8'h00, 1'b1);
    check("b_unchanged_after_err", alu_B_flat, 200'd0);
    simple_cmd(3'b000, 5'd0, 8'h00, 8'h00, 1'b0);

    simple_cmd(3'b010, 5'd0, 8'hFD, 8'h00, 1'b0);
    simple_cmd(3'b011, 5'd5, 8'h02, 8'h00, 1'b0);
    check("f_written", alu_f, 8'h02);

    // Add, done one cycle after the opcode: settle + 2 wait + resp.
    m_lat = 1;
    m_ovf = 1'b0;
    run_exec(3'b001, 8'h00, 1'b0, 4, 2, 1'b0);
    check("sticky_after_add", overflow_sticky, 1'b0);
    simple_cmd(3'b101, 5'd0, 8'h00, 8'h00, 1'b0);
    simple_cmd(3'b101, 5'd24, 8'h00, 8'h07, 1'b0);
    simple_cmd(3'b101, 5'd25, 8'h00, 8'h00, 1'b1);

    // Mul with overflow, done in the fifth wait cycle; host writes are ignored.
    m_lat = 4;
    m_ovf = 1'b1;
    run_exec(3'b011, 8'h01, 1'b0, 7, 5, 1'b1);
    check("ghost_write_ignored", alu_A_flat[15:8], 8'h00);
    check("sticky_after_mul", overflow_sticky, 1'b1);
    simple_cmd(3'b101, 5'd0, 8'h00, 8'hF7, 1'b0);
    simple_cmd(3'b101, 5'd24, 8'h00, 8'h00, 1'b0);

    // Done already high in the first wait cycle must be ignored.
    m_lat = 0;
    m_ovf = 1'b0;
    run_exec(3'b001, 8'h00, 1'b0, 4, 2, 1'b0);
    check("sticky_held", overflow_sticky, 1'b1);

    // Exec with idle opcode is an error and never enters wait.
    run_exec(3'b000, 8'h00, 1'b1, 1, 0, 1'b0);

    // Timeout: 64 wait cycles, C and sticky untouched.
    m_never = 1'b1;
    run_exec(3'b100, 8'h00, 1'b1, 66, 64, 1'b0);
    check("sticky_after_timeout", overflow_sticky, 1'b1);
    simple_cmd(3'b101, 5'd0, 8'h00, 8'h00, 1'b0);
    simple_cmd(3'b101, 5'd24, 8'h00, 8'h07, 1'b0);

    // Clear.
    simple_cmd(3'b110, 5'd0, 8'h00, 8'h00, 1'b0);
    check("clear_sticky", overflow_sticky, 1'b0);
    check("clear_a", alu_A_flat, 200'd0);
    check("clear_b", alu_B_flat, 200'd0);
    check("clear_f", alu_f, 8'h00);
    simple_cmd(3'b101, 5'd24, 8'h00, 8'h00, 1'b0);

    // Reset in the middle of a wait drops the exec silently.
    simple_cmd(3'b001, 5'd3, 8'h11, 8'h00, 1'b0);
    issue(3'b100, 5'd0, 8'h01, 8'h00, 1'b0, 1'b0);
    repeat (5) tick();
    check("mid_wait_opcode", alu_opcode, 3'b001);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_ready", cmd_ready, 1'b1);
    check("midreset_opcode", alu_opcode, 3'b000);
    check("midreset_a", alu_A_flat, 200'd0);
    repeat (4) tick();
    m_never = 1'b0;
    simple_cmd(3'b011, 5'd0, 8'h09, 8'h00, 1'b0);
    check("f_after_midreset", alu_f, 8'h09);

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
Command-driven controller that owns the matrix ALU (5x5 int8 operands A/B, scalar f, 3-bit opcode, done/overflow handshake). Host issues element-wise writes of A, B and f, then execute and read-back commands over a valid/ready port. The sequencer holds the operand and result registers, drives the ALU opcode, waits for done with a timeout, and captures C and overflow. It sits between the host/bus bridge and the ALU instance.

Parameters:
N_ELEM, 25, matrix elements (5x5, row-major, element i = r*5+c at bits [i*8 +: 8])
DATA_W, 8, element and scalar width (two's complement)
TIMEOUT_CYCLES, 64, maximum WAIT cycles before abort
CNT_W, 7, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clock  in  1  single clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer accepts command (high only in IDLE)
cmd_code  in  3  000 NOP, 001 WRITE_A, 010 WRITE_B, 011 WRITE_F, 100 EXEC, 101 READ_C, 110 CLEAR, 111 reserved
cmd_addr  in  5  element index 0..24
cmd_data  in  8  write data; EXEC uses [2:0] as ALU opcode
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_data  out  8  READ_C element; EXEC {7'b0, captured overflow}; else 0
rsp_error  out  1  qualifies rsp_valid
busy  out  1  high in any state except IDLE
overflow_sticky  out  1  OR of all captured ALU overflows since reset/CLEAR
alu_A_flat  out  200  operand A register
alu_B_flat  out  200  operand B register
alu_f  out  8  scalar register
alu_opcode  out  3  000 except in WAIT
alu_C_flat  in  200  ALU result
alu_overflow_flag  in  1  ALU overflow
alu_done  in  1  ALU completion

Behaviour:
- Reset (reset_n=0 at edge): state IDLE; A, B, C, f, overflow_sticky, counter = 0; alu_opcode=000; rsp_valid=rsp_error=0; rsp_data=0; busy=0. Applies mid-operation: any in-flight EXEC is dropped, no response.
- States: IDLE, RESP, SETTLE, WAIT.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready at edge N.
- Non-EXEC commands: effect applied at edge N; state RESP during cycle N+1 (rsp_valid=1, cmd_ready=0); IDLE at N+2. Max throughput one command per 2 cycles.
- WRITE_A/WRITE_B: element cmd_addr <= cmd_data. WRITE_F: f <= cmd_data (addr ignored). READ_C: rsp_data = C[cmd_addr]. CLEAR: A, B, C, f, overflow_sticky <= 0. NOP: rsp 0, no error.
- Errors (rsp_error=1, no state change): cmd_addr>24 on WRITE_A/WRITE_B/READ_C; EXEC with opcode 000; cmd_code 111.
- EXEC (valid): edge N -> SETTLE for one cycle (alu_opcode=000, clears stale done) -> WAIT, alu_opcode=op, counter counts cycles in WAIT.
- WAIT: first edge with alu_done=1 and counter>=1: C <= alu_C_flat, overflow_sticky |= alu_overflow_flag, latch overflow for rsp_data; -> RESP. alu_done in the first WAIT cycle is ignored.
- Timeout: counter reaches TIMEOUT_CYCLES without qualifying done -> RESP with rsp_error=1; C and overflow_sticky unchanged.
- alu_opcode returns to 000 in the cycle after leaving WAIT.
- cmd_valid while busy: ignored (cmd_ready=0); host must hold.
- A/B/f must not change during SETTLE/WAIT (guaranteed by cmd_ready=0).

Decomposition:
- Package coproc_pkg: command code constants, ALU opcode constants (000 idle, 001 add, 010 sub, 011 mul, 100 neg, 101 transpose, 110 scalar, 111 det), state enum, N_ELEM, DATA_W, element slice helper.
- Sub-module matrix_bank: 25x8 register bank with synchronous write-by-index, clear, and flat 200-bit output; instantiated for A and B. C uses a plain 200-bit register.

Test Plan:
- Reset: reset_n low 2 cycles then high -> cmd_ready=1, busy=0, alu_opcode=000, all flats 0.
- WRITE_A addr 0 data 0x03, addr 24 data 0x07 -> alu_A_flat[7:0]=0x03, [199:192]=0x07; rsp_valid exactly one cycle after each accept, rsp_error=0.
- WRITE_B addr 25 data 0xFF, and cmd_code 111 -> rsp_error=1, alu_B_flat unchanged.
- EXEC op 001 with A[0]=0x03, B[0]=0xFD, ALU model done 1 cycle after opcode -> alu_opcode=001 only in WAIT; READ_C addr 0 returns 0x00; rsp_data of EXEC = 0.
- EXEC op 011, model done after 5 cycles with overflow=1 -> busy high 1+5+1 cycles, cmd_valid ignored meanwhile, rsp_data=0x01, overflow_sticky=1 until CLEAR.
- Model never asserts done -> rsp_error=1 after 64 WAIT cycles, C unchanged; repeat with reset_n low during WAIT -> no response, IDLE next cycle, opcode 000.
